vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
Sink-side VGA timing receiver. Consumes the hs/vs/blank/RGB stream produced by the 640x480 VGA timing generator, or an external source, on the pixel clock. Measures line and frame geometry, declares lock after consecutive conforming frames, and emits a pixel write stream (x, y, RGB) for framebuffer capture and self-check of the display path.

Parameters:
H_TOTAL, 800, expected clocks per line (hs falling edge to next hs falling edge)
H_DISP, 640, expected active (blank high) pixels per line
V_TOTAL, 525, expected lines per frame (vs falling edge to next vs falling edge)
V_DISP, 480, expected lines containing at least one active pixel
LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
clk  in  1  pixel clock, 25MHz; all logic on rising edge
rst  in  1  synchronous active-high reset
i_vga_hs  in  1  line sync, active low
i_vga_vs  in  1  frame sync, active low
i_vga_blank  in  1  high = active display pixel
i_vga_r  in  8  red
i_vga_g  in  8  green
i_vga_b  in  8  blue
o_locked  out  1  geometry locked
o_err  out  1  one-cycle pulse on loss of lock
o_err_cnt  out  8  loss-of-lock count, saturates at 255
o_meas_h  out  11  last measured line length
o_meas_v  out  11  last measured frame length in lines
o_pix_valid  out  1  pixel write strobe
o_pix_x  out  10  pixel column, 0-based
o_pix_y  out  10  pixel row, 0-based
o_pix_rgb  out  24  {r,g,b}
o_frame_start  out  1  pulse coincident with pixel (0,0) write
o_frame_crc  out  16  per-frame checksum (optional feature)

Behaviour:
- Reset: all outputs 0; FSM to SEARCH; all counters 0; input register stage cleared (hs/vs registered as 1).
- Input stage: all inputs registered once. Edges are detected on the registered copies. Line start = hs 1->0. Frame start = vs 1->0.
- h_cnt: cleared to 0 on line start, otherwise +1, saturating at 2047. Line length = h_cnt+1 at the next line start. o_meas_h is updated at each line start.
- Line counter: cleared on frame start, +1 on each line start. o_meas_v is latched at frame start.
- Active counters: act_x counts active pixels in the current line. act_y counts lines with act_x>0, evaluated at line start.
- A frame is good only if every line length is H_TOTAL, every nonzero act_x equals H_DISP, the line count is V_TOTAL, and act_y equals V_DISP.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH -> MEASURE on frame start; good_cnt=0.
  - MEASURE, at frame start: good frame -> good_cnt+1; bad frame -> good_cnt=0, stay in MEASURE. When good_cnt reaches LOCK_FRAMES -> LOCKED.
  - LOCKED -> SEARCH immediately, with o_err pulse and o_err_cnt+1 (saturating), on any of: h_cnt reaching H_TOTAL with no line start; line count reaching V_TOTAL with no frame start; act_x exceeding H_DISP; a bad frame evaluated at frame start.
  - A simultaneous good frame start and violation counts as a violation.
- o_locked = (state==LOCKED), registered. It rises the cycle after the qualifying frame start.
- Pixel path: o_pix_valid=1 only in LOCKED with registered blank=1 and act_x<H_DISP. Latency is 2 clk from input pins to o_pix_*. x = act_x before increment; y = act_y.
- o_pix_x/y/rgb hold their last values when o_pix_valid=0.
- The o_pix_valid that causes loss of lock is suppressed.
- o_frame_start = o_pix_valid && x==0 && y==0.

Optional Feature:
VGA_CAPTURE_CRC_EN defined:
- A 16-bit accumulator adds r+g+b (zero-extended) for every o_pix_valid pixel, modulo 2^16.
- At frame start the accumulator is latched into o_frame_crc and then cleared.
- Reset clears both the accumulator and o_frame_crc.

VGA_CAPTURE_CRC_EN undefined:
- o_frame_crc is tied to 16'd0 and no accumulator is built.

Test Plan:
- Reset, then nominal 800x525/640x480 source (sync pulses 96 and 2) -> o_locked=1 one cycle after the 3rd vs falling edge; o_meas_h=800; o_meas_v=525; o_err_cnt=0.
- Locked; first active pixel driven as 0x123456 -> 2 clk later o_pix_valid=1, x=0, y=0, rgb=0x123456, o_frame_start=1; last pixel x=639, y=479; exactly 307200 strobes per frame.
- Locked; one line stretched to 801 clk -> o_err pulse when h_cnt reaches 800; o_locked=0; o_err_cnt=1; relock after 3 frame starts.
- Locked; one line with 641 active pixels -> 641st pixel gives no strobe, o_err pulses, state goes to SEARCH.
- rst asserted mid-frame for 1 clk -> all outputs 0 next cycle; relock after 3 frame starts.
- VGA_CAPTURE_CRC_EN defined, constant color r=g=b=1 -> o_frame_crc = (307200*3) mod 65536 = 4096 after the 2nd locked frame start.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: VGA timing receiver; measures line/frame geometry, locks, emits pixel write stream.
// Latency: 2 clk from input pins to o_pix_*; lock/err update 1 clk after a registered sync edge.
// Backpressure: none; the source is free-running and every o_pix_valid strobe must be consumed.
// Optional: define VGA_CAPTURE_CRC_EN to build the per-frame pixel checksum on o_frame_crc.
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int H_DISP      = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_DISP      = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vga_hs,
  input  logic        i_vga_vs,
  input  logic        i_vga_blank,
  input  logic [7:0]  i_vga_r,
  input  logic [7:0]  i_vga_g,
  input  logic [7:0]  i_vga_b,
  output logic        o_locked,
  output logic        o_err,
  output logic [7:0]  o_err_cnt,
  output logic [10:0] o_meas_h,
  output logic [10:0] o_meas_v,
  output logic        o_pix_valid,
  output logic [9:0]  o_pix_x,
  output logic [9:0]  o_pix_y,
  output logic [23:0] o_pix_rgb,
  output logic        o_frame_start,
  output logic [15:0] o_frame_crc
);

  localparam logic [1:0]  ST_SEARCH  = 2'd0;
  localparam logic [1:0]  ST_MEASURE = 2'd1;
  localparam logic [1:0]  ST_LOCKED  = 2'd2;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_DISP);
  localparam logic [10:0] V_ACT  = 11'(V_DISP);
  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic        hs_q, hs_qq, vs_q, vs_qq, blank_q;
  logic [23:0] rgb_q;
  logic [10:0] h_cnt, line_cnt, act_x, act_y;
  logic        frame_bad;
  logic [1:0]  state, state_nxt;
  logic [3:0]  good_cnt, good_nxt;

  logic        line_start, frame_start, line_bad, frame_good;
  logic        h_over, v_over, x_over, viol, pix_valid;
  logic [10:0] act_x_cur, act_y_cur, act_y_end;

  // Sync edges are taken between the first and second register stages.
  assign line_start  = hs_qq & ~hs_q;
  assign frame_start = vs_qq & ~vs_q;

  // Counts as seen by the current pixel: a sync edge restarts them this cycle.
  assign act_x_cur = line_start  ? 11'd0 : act_x;
  assign act_y_cur = frame_start ? 11'd0 : act_y;

  // The line closing at this line start: wrong length, or active but not full width.
  assign line_bad  = (h_cnt != H_LAST) || ((act_x != 11'd0) && (act_x != H_ACT));
  // A closing line with active pixels still counts toward the frame it ends.
  assign act_y_end = act_y + ((line_start && (act_x != 11'd0)) ? 11'd1 : 11'd0);
  assign frame_good = !frame_bad && !(line_start && line_bad) &&
                      (line_cnt == V_LAST) && (act_y_end == V_ACT);

  // Overruns are flagged on the cycle the counter would step past its expected total.
  assign h_over = !line_start && (h_cnt == H_LAST);
  assign v_over = line_start && !frame_start && (line_cnt == V_LAST);
  assign x_over = blank_q && (act_x_cur >= H_ACT);
  assign viol   = (state == ST_LOCKED) &&
                  (h_over || v_over || x_over || (frame_start && !frame_good));

  // The strobe on the cycle that drops lock is suppressed.
  assign pix_valid = (state == ST_LOCKED) && blank_q && (act_x_cur < H_ACT) && !viol;

  // Input register stage plus delayed sync copies for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 1'b1;
      hs_qq   <= 1'b1;
      vs_q    <= 1'b1;
      vs_qq   <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs_q    <= i_vga_hs;
      hs_qq   <= hs_q;
      vs_q    <= i_vga_vs;
      vs_qq   <= vs_q;
      blank_q <= i_vga_blank;
      rgb_q   <= {i_vga_r, i_vga_g, i_vga_b};
    end
  end

  // Horizontal position counter and line length measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt    <= '0;
      o_meas_h <= '0;
    end else if (line_start) begin
      h_cnt    <= '0;
      o_meas_h <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
    end else if (h_cnt != CNT_MAX) begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Line, active-pixel and active-line counters, frame length and per-frame error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt  <= '0;
      act_x     <= '0;
      act_y     <= '0;
      frame_bad <= 1'b0;
      o_meas_v  <= '0;
    end else begin
      act_x <= (blank_q && (act_x_cur != CNT_MAX)) ? act_x_cur + 11'd1 : act_x_cur;
      if (frame_start) begin
        line_cnt  <= '0;
        act_y     <= '0;
        frame_bad <= 1'b0;
        o_meas_v  <= (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + 11'd1;
      end else if (line_start) begin
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 11'd1;
        if ((act_x != 11'd0) && (act_y != CNT_MAX)) act_y <= act_y + 11'd1;
        if (line_bad) frame_bad <= 1'b1;
      end
    end
  end

  // Lock state machine next-state and good-frame count.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      ST_SEARCH: begin
        if (frame_start) begin
          state_nxt = ST_MEASURE;
          good_nxt  = '0;
        end
      end
      ST_MEASURE: begin
        if (frame_start) begin
          if (frame_good) begin
            good_nxt = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_N) state_nxt = ST_LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (viol) begin
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        good_nxt  = '0;
      end
    endcase
  end

  // State register, lock flag and loss-of-lock reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      good_cnt  <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      o_locked <= (state_nxt == ST_LOCKED);
      o_err    <= viol;
      if (viol && (o_err_cnt != 8'hff)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  // Pixel write stream; coordinates and colour hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pix_valid   <= 1'b0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_pix_rgb     <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_pix_valid   <= pix_valid;
      o_frame_start <= pix_valid && (act_x_cur == 11'd0) && (act_y_cur == 11'd0);
      if (pix_valid) begin
        o_pix_x   <= act_x_cur[9:0];
        o_pix_y   <= act_y_cur[9:0];
        o_pix_rgb <= rgb_q;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_acc;
  logic [15:0] pix_sum;

  assign pix_sum = 16'(rgb_q[23:16]) + 16'(rgb_q[15:8]) + 16'(rgb_q[7:0]);

  // Per-frame sum of r+g+b over strobed pixels, published at each frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc     <= '0;
      o_frame_crc <= '0;
    end else if (frame_start) begin
      o_frame_crc <= crc_acc;
      crc_acc     <= pix_valid ? pix_sum : 16'd0;
    end else if (pix_valid) begin
      crc_acc <= crc_acc + pix_sum;
    end
  end
`else
  assign o_frame_crc = 16'd0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed checks of vga_capture on a reduced 20x10 / 12x6 raster.
// Latency: pixel strobes 2 clk after pins; lock 2 clk after the driven vs fall.
// Backpressure: none; stimulus is a free-running raster.
module tb_vga_capture;
  localparam int HT = 20;
  localparam int HD = 12;
  localparam int VT = 10;
  localparam int VD = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        o_locked, o_err, o_pix_valid, o_frame_start;
  logic [7:0]  o_err_cnt;
  logic [10:0] o_meas_h, o_meas_v;
  logic [9:0]  o_pix_x, o_pix_y;
  logic [23:0] o_pix_rgb;
  logic [15:0] o_frame_crc;

  vga_capture #(.H_TOTAL(HT), .H_DISP(HD), .V_TOTAL(VT), .V_DISP(VD), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .i_vga_hs(hs), .i_vga_vs(vs), .i_vga_blank(blank),
    .i_vga_r(vga_r), .i_vga_g(vga_g), .i_vga_b(vga_b),
    .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt),
    .o_meas_h(o_meas_h), .o_meas_v(o_meas_v), .o_pix_valid(o_pix_valid),
    .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_rgb(o_pix_rgb),
    .o_frame_start(o_frame_start), .o_frame_crc(o_frame_crc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;
  logic const_color = 1'b0;

  // driver timestamps
  int vs_fall_cyc = 0, first_pix_cyc = 0, stretch_cyc = 0, wide_cyc = 0, reset_cyc = 0;

  // monitor state (monotonic counters; tasks take baselines)
  int strobes = 0, strobes_y1 = 0, bad_x = 0, fs_cnt = 0, err_pulses = 0;
  int fs_cyc = 0, err_cyc = 0, rise_cyc = 0, snap_cyc = 0;
  logic [9:0]  last_x = '0, last_y = '0, fs_x = '0, fs_y = '0;
  logic [23:0] last_rgb = '0, fs_rgb = '0;
  logic        locked_prev = 1'b0;
  logic        rst_d = 1'b0;
  logic        snap_locked = 1'b1, snap_err = 1'b1, snap_pv = 1'b1, snap_fs = 1'b1;
  logic [7:0]  snap_err_cnt = '1;
  logic [21:0] snap_meas = '1;
  logic [43:0] snap_pix = '1;

  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    if (o_pix_valid) begin
      strobes++;
      if (o_pix_y == 10'd1) strobes_y1++;
      if (o_pix_x >= 10'(HD)) bad_x++;
      last_x = o_pix_x; last_y = o_pix_y; last_rgb = o_pix_rgb;
      if (o_frame_start) begin
        fs_cnt++; fs_cyc = cyc; fs_rgb = o_pix_rgb; fs_x = o_pix_x; fs_y = o_pix_y;
      end
    end
    if (o_err) begin err_pulses++; err_cyc = cyc; end
    if (o_locked && !locked_prev) rise_cyc = cyc;
    locked_prev = o_locked;
    if (rst_d) begin
      snap_cyc = cyc; snap_locked = o_locked; snap_err = o_err; snap_err_cnt = o_err_cnt;
      snap_meas = {o_meas_h, o_meas_v}; snap_pv = o_pix_valid; snap_fs = o_frame_start;
      snap_pix = {o_pix_x, o_pix_y, o_pix_rgb};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  // One frame: hs low hp 0..1, vs low lines 0..1, active lines 2..7, pixels hp 4..15.
  task automatic send_frame(input int stretch_lp, input int wide_lp, input int reset_lp);
    int len;
    logic [23:0] pix;
    for (int lp = 0; lp < VT; lp++) begin
      len = (lp == stretch_lp) ? HT + 1 : HT;
      for (int hp = 0; hp < len; hp++) begin
        @(posedge clk); #1;
        hs = (hp >= 2);
        vs = (lp >= 2);
        blank = (lp >= 2) && (lp < 2 + VD) && (hp >= 4) &&
                (hp < ((lp == wide_lp) ? 4 + HD + 1 : 4 + HD));
        if (const_color) pix = 24'h010101;
        else if (lp == 2 && hp == 4) pix = 24'h123456;
        else pix = {8'(lp), 8'(hp), 8'h5A};
        {vga_r, vga_g, vga_b} = pix;
        rst = (lp == reset_lp) && (hp == 8);
        if (lp == 0 && hp == 0) vs_fall_cyc = cyc;
        if (lp == 2 && hp == 4) first_pix_cyc = cyc;
        if (lp == stretch_lp && hp == 0) stretch_cyc = cyc;
        if (lp == wide_lp && hp == 4 + HD) wide_cyc = cyc;
        if (rst) reset_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0h want 0", o_locked); end
    checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0h want 0", o_err); end
    checks++; if (o_err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt: got %0h want 0", o_err_cnt); end
    checks++; if ({o_meas_h, o_meas_v} !== 22'd0) begin fails++; $display("FAIL reset_meas: got %0h/%0h want 0", o_meas_h, o_meas_v); end
    checks++; if (o_pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid: got %0h want 0", o_pix_valid); end
    checks++; if ({o_pix_x, o_pix_y, o_pix_rgb} !== 44'd0) begin fails++; $display("FAIL reset_pix: got %0h/%0h/%0h want 0", o_pix_x, o_pix_y, o_pix_rgb); end
    checks++; if (o_frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %0h want 0", o_frame_start); end
    checks++; if (o_frame_crc !== 16'd0) begin fails++; $display("FAIL reset_crc: got %0h want 0", o_frame_crc); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lock();
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %0h want 0", o_locked); end
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b1) begin fails++; $display("FAIL lock_locked: got %0h want 1", o_locked); end
    checks++; if (rise_cyc - vs_fall_cyc !== 2) begin fails++; $display("FAIL lock_timing: got %0d want 2", rise_cyc - vs_fall_cyc); end
    checks++; if (o_meas_h !== 11'd20) begin fails++; $display("FAIL lock_meas_h: got %0d want 20", o_meas_h); end
    checks++; if (o_meas_v !== 11'd10) begin fails++; $display("FAIL lock_meas_v: got %0d want 10", o_meas_v); end
    checks++; if (o_err_cnt !== 8'd0) begin fails++; $display("FAIL lock_err_cnt: got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_pixels();
    int base_s, base_fs;
    base_s = strobes; base_fs = fs_cnt;
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (strobes - base_s !== 72) begin fails++; $display("FAIL pix_count: got %0d want 72", strobes - base_s); end
    checks++; if (fs_cnt - base_fs !== 1) begin fails++; $display("FAIL pix_frame_start_count: got %0d want 1", fs_cnt - base_fs); end
    checks++; if (fs_rgb !== 24'h123456) begin fails++; $display("FAIL pix_first_rgb: got %0h want 123456", fs_rgb); end
    checks++; if ({fs_x, fs_y} !== 20'd0) begin fails++; $display("FAIL pix_first_xy: got %0d,%0d want 0,0", fs_x, fs_y); end
    checks++; if (fs_cyc - first_pix_cyc !== 2) begin fails++; $display("FAIL pix_latency: got %0d want 2", fs_cyc - first_pix_cyc); end
    checks++; if (last_x !== 10'd11 || last_y !== 10'd5) begin fails++; $display("FAIL pix_last_xy: got %0d,%0d want 11,5", last_x, last_y); end
    checks++; if (last_rgb !== 24'h070F5A) begin fails++; $display("FAIL pix_last_rgb: got %0h want 070f5a", last_rgb); end
    checks++; if (o_pix_valid !== 1'b0 || o_pix_x !== 10'd11 || o_pix_y !== 10'd5) begin fails++; $display("FAIL pix_hold: got v=%0h %0d,%0d want v=0 11,5", o_pix_valid, o_pix_x, o_pix_y); end
    checks++; if (o_locked !== 1'b1) begin fails++; $display("FAIL pix_still_locked: got %0h want 1", o_locked); end
  endtask

  task automatic test_crc();
    logic [15:0] exp_crc;
`ifdef VGA_CAPTURE_CRC_EN
    exp_crc = 16'd216;
`else
    exp_crc = 16'd0;
`endif
    const_color = 1'b1;
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    const_color = 1'b0;
    @(negedge clk);
    checks++; if (o_frame_crc !== exp_crc) begin fails++; $display("FAIL crc_value: got %0d want %0d", o_frame_crc, exp_crc); end
    checks++; if (o_locked !== 1'b1) begin fails++; $display("FAIL crc_locked: got %0h want 1", o_locked); end
  endtask

  task automatic test_long_line();
    int base_e;
    base_e = err_pulses;
    send_frame(-1, -1, -1);
    send_frame(4, -1, -1);
    @(negedge clk);
    checks++; if (err_pulses - base_e !== 1) begin fails++; $display("FAIL long_err_pulses: got %0d want 1", err_pulses - base_e); end
    checks++; if (err_cyc - stretch_cyc !== HT + 2) begin fails++; $display("FAIL long_err_timing: got %0d want %0d", err_cyc - stretch_cyc, HT + 2); end
    checks++; if (o_locked !== 1'b0) begin fails++; $display("FAIL long_unlocked: got %0h want 0", o_locked); end
    checks++; if (o_err_cnt !== 8'd1) begin fails++; $display("FAIL long_err_cnt: got %0d want 1", o_err_cnt); end
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b0) begin fails++; $display("FAIL long_relock_early: got %0h want 0", o_locked); end
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b1 || o_err_cnt !== 8'd1) begin fails++; $display("FAIL long_relock: got lock=%0h cnt=%0d want 1,1", o_locked, o_err_cnt); end
  endtask

  task automatic test_wide_line();
    int base_e, base_s, base_y1, base_bx;
    base_e = err_pulses; base_s = strobes; base_y1 = strobes_y1; base_bx = bad_x;
    send_frame(-1, 3, -1);
    @(negedge clk);
    checks++; if (err_pulses - base_e !== 1) begin fails++; $display("FAIL wide_err_pulses: got %0d want 1", err_pulses - base_e); end
    checks++; if (err_cyc - wide_cyc !== 2) begin fails++; $display("FAIL wide_err_timing: got %0d want 2", err_cyc - wide_cyc); end
    checks++; if (strobes_y1 - base_y1 !== 12) begin fails++; $display("FAIL wide_line_strobes: got %0d want 12", strobes_y1 - base_y1); end
    checks++; if (strobes - base_s !== 24) begin fails++; $display("FAIL wide_frame_strobes: got %0d want 24", strobes - base_s); end
    checks++; if (bad_x - base_bx !== 0) begin fails++; $display("FAIL wide_x_range: got %0d want 0", bad_x - base_bx); end
    checks++; if (o_locked !== 1'b0 || o_err_cnt !== 8'd2) begin fails++; $display("FAIL wide_state: got lock=%0h cnt=%0d want 0,2", o_locked, o_err_cnt); end
  endtask

  task automatic test_mid_reset();
    repeat (3) send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b1) begin fails++; $display("FAIL mrst_prelock: got %0h want 1", o_locked); end
    send_frame(-1, -1, 3);
    @(negedge clk);
    checks++; if (snap_cyc - reset_cyc !== 1) begin fails++; $display("FAIL mrst_snap_timing: got %0d want 1", snap_cyc - reset_cyc); end
    checks++; if (snap_locked !== 1'b0 || snap_err !== 1'b0) begin fails++; $display("FAIL mrst_flags: got %0h,%0h want 0,0", snap_locked, snap_err); end
    checks++; if (snap_err_cnt !== 8'd0) begin fails++; $display("FAIL mrst_err_cnt: got %0d want 0", snap_err_cnt); end
    checks++; if (snap_meas !== 22'd0) begin fails++; $display("FAIL mrst_meas: got %0h want 0", snap_meas); end
    checks++; if (snap_pv !== 1'b0 || snap_fs !== 1'b0 || snap_pix !== 44'd0) begin fails++; $display("FAIL mrst_pix: got v=%0h fs=%0h pix=%0h want 0", snap_pv, snap_fs, snap_pix); end
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b0) begin fails++; $display("FAIL mrst_relock_early: got %0h want 0", o_locked); end
    send_frame(-1, -1, -1);
    @(negedge clk);
    checks++; if (o_locked !== 1'b1 || o_err_cnt !== 8'd0) begin fails++; $display("FAIL mrst_relock: got lock=%0h cnt=%0d want 1,0", o_locked, o_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_crc();
    test_long_line();
    test_wide_line();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
